memstage: RTL and testbench

Memory-access stage of the five-stage semiMIPS pipeline, between the EX/MEM and writeback stages. It resolves conditional branches and jumps from the EX/MEM flags and drives PC redirect and flush. It runs data-memory loads and stores over a req/ack handshake with a wait-state FSM and timeout watchdog, stalling upstream while busy. Its MEM/WB output register feeds writeback.

---
 rtl/memstage_pkg.sv | 18 +
 rtl/memstage_memwbreg.sv | 96 +++++++++
 rtl/memstage.sv | 188 ++++++++++++++++++
 tb/tb_memstage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/memstage_pkg.sv
// Shared encodings for the semiMIPS memory-access stage: FSM states, PC source
// select values and writeback mux selects.
package memstage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

endpackage

// File: rtl/memstage_memwbreg.sv
// MEM/WB pipeline register. A load captures every field; a bubble clears the
// writeback controls and leaves the datapath fields holding.
module memwbreg
  import memstage_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [1:0]        memtoreg_i,
  input  logic              regwr_i,
  input  logic              fin_i,
  input  logic [DWIDTH-1:0] aluout_i,
  input  logic [DWIDTH-1:0] memdata_i,
  input  logic [4:0]        regdst_i,
  input  logic [AWIDTH-1:0] pcnext_i,
  input  logic [31:0]       ins_i,
  output logic [1:0]        memtoreg_o,
  output logic              regwr_o,
  output logic              fin_o,
  output logic [DWIDTH-1:0] aluout_o,
  output logic [DWIDTH-1:0] memdata_o,
  output logic [4:0]        regdst_o,
  output logic [AWIDTH-1:0] pcnext_o,
  output logic [31:0]       ins_o
);

  logic [1:0]        memtoreg_q, memtoreg_d;
  logic              regwr_q, regwr_d;
  logic              fin_q, fin_d;
  logic [DWIDTH-1:0] aluout_q, aluout_d;
  logic [DWIDTH-1:0] memdata_q, memdata_d;
  logic [4:0]        regdst_q, regdst_d;
  logic [AWIDTH-1:0] pcnext_q, pcnext_d;
  logic [31:0]       ins_q, ins_d;

  always_comb begin
    memtoreg_d = memtoreg_q;
    regwr_d    = regwr_q;
    fin_d      = fin_q;
    aluout_d   = aluout_q;
    memdata_d  = memdata_q;
    regdst_d   = regdst_q;
    pcnext_d   = pcnext_q;
    ins_d      = ins_q;
    if (load_i) begin
      memtoreg_d = memtoreg_i;
      regwr_d    = regwr_i;
      fin_d      = fin_i;
      aluout_d   = aluout_i;
      memdata_d  = memdata_i;
      regdst_d   = regdst_i;
      pcnext_d   = pcnext_i;
      ins_d      = ins_i;
    end else if (bubble_i) begin
      memtoreg_d = MTR_ALU;
      regwr_d    = 1'b0;
      fin_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memtoreg_q <= '0;
      regwr_q    <= 1'b0;
      fin_q      <= 1'b0;
      aluout_q   <= '0;
      memdata_q  <= '0;
      regdst_q   <= '0;
      pcnext_q   <= '0;
      ins_q      <= '0;
    end else begin
      memtoreg_q <= memtoreg_d;
      regwr_q    <= regwr_d;
      fin_q      <= fin_d;
      aluout_q   <= aluout_d;
      memdata_q  <= memdata_d;
      regdst_q   <= regdst_d;
      pcnext_q   <= pcnext_d;
      ins_q      <= ins_d;
    end
  end

  assign memtoreg_o = memtoreg_q;
  assign regwr_o    = regwr_q;
  assign fin_o      = fin_q;
  assign aluout_o   = aluout_q;
  assign memdata_o  = memdata_q;
  assign regdst_o   = regdst_q;
  assign pcnext_o   = pcnext_q;
  assign ins_o      = ins_q;

endmodule

// File: rtl/memstage.sv
// semiMIPS memory-access stage: branch/jump resolution, data-memory req/ack
// sequencing with a timeout watchdog, and the MEM/WB register.
module memstage
  import memstage_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwr,
  input  logic              memrd,
  input  logic              bbne,
  input  logic              bbeq,
  input  logic              bblez,
  input  logic              bbgtz,
  input  logic              jump,
  input  logic [1:0]        memtoreg,
  input  logic              regwr,
  input  logic              fin,
  input  logic [DWIDTH-1:0] aluout,
  input  logic              zero,
  input  logic              negative,
  input  logic [4:0]        regdstmux,
  input  logic [DWIDTH-1:0] regdata2,
  input  logic [AWIDTH-1:0] branaddr,
  input  logic [AWIDTH-1:0] jmpaddr,
  input  logic [AWIDTH-1:0] pcnext,
  input  logic [31:0]       ins,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  input  logic [DWIDTH-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        pcsrc,
  output logic [AWIDTH-1:0] pctarget,
  output logic              memerr,
  output logic [1:0]        memtoregout,
  output logic              regwrout,
  output logic              finout,
  output logic [DWIDTH-1:0] aluoutout,
  output logic [DWIDTH-1:0] memdataout,
  output logic [4:0]        regdstmuxout,
  output logic [AWIDTH-1:0] pcnextout,
  output logic [31:0]       insout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              memerr_q, memerr_d;

  logic              taken, access, is_read;
  logic              wb_load, wb_bubble, wb_regwr;
  logic [DWIDTH-1:0] wb_memdata;

  assign taken = (bbeq & zero) | (bbne & ~zero) | (bblez & (zero | negative))
               | (bbgtz & ~zero & ~negative);
  assign flush = jump | taken;

  always_comb begin
    pcsrc    = PC_SEQ;
    pctarget = pcnext;
    if (jump) begin
      pcsrc    = PC_JMP;
      pctarget = jmpaddr;
    end else if (taken) begin
      pcsrc    = PC_BR;
      pctarget = branaddr;
    end
  end

  // A simultaneous read and write request is performed as a write.
  assign access  = memrd | memwr;
  assign is_read = memrd & ~memwr;
  assign stall   = (state_q == ST_BUSY) | access;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    memerr_d   = memerr_q;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_regwr   = regwr;
    wb_memdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          addr_d    = aluout;
          wdata_d   = regdata2;
          we_d      = memwr;
          req_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_BUSY;
          wb_bubble = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          wb_load = 1'b1;
          if (is_read) wb_memdata = dmem_rdata;
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          // Abandon the access: the load result is dropped, the store is lost.
          req_d    = 1'b0;
          memerr_d = 1'b1;
          wb_load  = 1'b1;
          wb_regwr = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          wb_bubble = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      memerr_q <= memerr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign memerr     = memerr_q;

  memwbreg #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_memwb (
    .clk       (clk),
    .rst       (rst),
    .load_i    (wb_load),
    .bubble_i  (wb_bubble),
    .memtoreg_i(memtoreg),
    .regwr_i   (wb_regwr),
    .fin_i     (fin),
    .aluout_i  (aluout),
    .memdata_i (wb_memdata),
    .regdst_i  (regdstmux),
    .pcnext_i  (pcnext),
    .ins_i     (ins),
    .memtoreg_o(memtoregout),
    .regwr_o   (regwrout),
    .fin_o     (finout),
    .aluout_o  (aluoutout),
    .memdata_o (memdataout),
    .regdst_o  (regdstmuxout),
    .pcnext_o  (pcnextout),
    .ins_o     (insout)
  );

endmodule

// File: tb/tb_memstage.sv
// Directed bench for memstage: ALU pass-through, load/store handshakes,
// branch/jump redirect, timeout watchdog and reset during an access.
module tb_memstage;
  import memstage_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst;
  logic          memwr, memrd, bbne, bbeq, bblez, bbgtz, jump;
  logic [1:0]    memtoreg;
  logic          regwr, fin, zero, negative;
  logic [DW-1:0] aluout, regdata2, dmem_rdata;
  logic [4:0]    regdstmux;
  logic [AW-1:0] branaddr, jmpaddr, pcnext;
  logic [31:0]   ins;
  logic          dmem_ack;
  logic          dmem_req, dmem_we, stall, flush, memerr;
  logic [AW-1:0] dmem_addr, pctarget, pcnextout;
  logic [DW-1:0] dmem_wdata, aluoutout, memdataout;
  logic [1:0]    pcsrc, memtoregout;
  logic          regwrout, finout;
  logic [4:0]    regdstmuxout;
  logic [31:0]   insout;

  int checks;
  int failures;
  int sc;
  int busy;

  memstage #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .memwr(memwr), .memrd(memrd), .bbne(bbne),
    .bbeq(bbeq), .bblez(bblez), .bbgtz(bbgtz), .jump(jump),
    .memtoreg(memtoreg), .regwr(regwr), .fin(fin), .aluout(aluout),
    .zero(zero), .negative(negative), .regdstmux(regdstmux),
    .regdata2(regdata2), .branaddr(branaddr), .jmpaddr(jmpaddr),
    .pcnext(pcnext), .ins(ins), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .pctarget(pctarget), .memerr(memerr), .memtoregout(memtoregout),
    .regwrout(regwrout), .finout(finout), .aluoutout(aluoutout),
    .memdataout(memdataout), .regdstmuxout(regdstmuxout),
    .pcnextout(pcnextout), .insout(insout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    memwr = 0; memrd = 0; bbne = 0; bbeq = 0; bblez = 0; bbgtz = 0; jump = 0;
    memtoreg = 0; regwr = 0; fin = 0; aluout = 0; zero = 0; negative = 0;
    regdstmux = 0; regdata2 = 0; branaddr = 0; jmpaddr = 0; pcnext = 0;
    ins = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    nop();
    tick();
    tick();
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_memerr", memerr, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_aluoutout", aluoutout, 0);
    rst = 1'b0;

    // ALU op: one-cycle pass-through
    aluout = 32'h1234; regwr = 1; regdstmux = 5; fin = 1;
    pcnext = 32'h8; ins = 32'h0123_4567;
    #1;
    check("alu_stall", stall, 0);
    check("alu_flush", flush, 0);
    check("alu_pcsrc", pcsrc, PC_SEQ);
    check("alu_pctarget", pctarget, 32'h8);
    tick();
    check("alu_aluoutout", aluoutout, 32'h1234);
    check("alu_regwrout", regwrout, 1);
    check("alu_regdst", regdstmuxout, 5);
    check("alu_fin", finout, 1);
    check("alu_ins", insout, 32'h0123_4567);
    check("alu_pcnext", pcnextout, 32'h8);
    check("alu_memdata", memdataout, 0);

    // Load, ack three cycles after req rises
    nop();
    memrd = 1; aluout = 32'h40; regwr = 1; memtoreg = MTR_MEM; regdstmux = 7;
    #1;
    sc = 0;
    for (int c = 0; c < 4; c++) begin
      if (stall) sc++;
      if (c == 3) begin
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      end
      tick();
      if (c < 3) begin
        check("ld_req", dmem_req, 1);
        check("ld_addr", dmem_addr, 32'h40);
        check("ld_we", dmem_we, 0);
        check("ld_bubble", regwrout, 0);
      end
    end
    nop();
    #1;
    check("ld_stall_cycles", sc, 4);
    check("ld_stall_after", stall, 0);
    check("ld_req_after", dmem_req, 0);
    check("ld_memdata", memdataout, 32'hDEAD_BEEF);
    check("ld_regwr", regwrout, 1);
    check("ld_memtoreg", memtoregout, MTR_MEM);
    check("ld_regdst", regdstmuxout, 7);

    // Store, ack in the first request cycle
    memwr = 1; aluout = 32'h80; regdata2 = 32'h55;
    #1;
    sc = 0;
    if (stall) sc++;
    tick();
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'h55);
    check("st_addr", dmem_addr, 32'h80);
    check("st_req", dmem_req, 1);
    if (stall) sc++;
    dmem_ack = 1;
    tick();
    nop();
    #1;
    check("st_stall_cycles", sc, 2);
    check("st_stall_after", stall, 0);
    check("st_req_after", dmem_req, 0);
    check("st_memdata", memdataout, 0);

    // Read and write together behave as a write
    memrd = 1; memwr = 1; aluout = 32'h90; regdata2 = 32'h77;
    tick();
    check("rw_we", dmem_we, 1);
    check("rw_wdata", dmem_wdata, 32'h77);
    dmem_ack = 1; dmem_rdata = 32'hAA;
    tick();
    nop();
    #1;
    check("rw_memdata", memdataout, 0);

    // Branch / jump resolution
    pcnext = 32'h44; branaddr = 32'h100; jmpaddr = 32'h200;
    bbeq = 1; zero = 1;
    #1;
    check("beq_pcsrc", pcsrc, PC_BR);
    check("beq_target", pctarget, 32'h100);
    check("beq_flush", flush, 1);
    bbeq = 0; zero = 0; bbgtz = 1; negative = 1;
    #1;
    check("bgtz_pcsrc", pcsrc, PC_SEQ);
    check("bgtz_flush", flush, 0);
    check("bgtz_target", pctarget, 32'h44);
    bbgtz = 0; bblez = 1;
    #1;
    check("blez_pcsrc", pcsrc, PC_BR);
    bblez = 0; negative = 0; bbne = 1;
    #1;
    check("bne_pcsrc", pcsrc, PC_BR);
    bbne = 0; bbeq = 1; zero = 1; jump = 1;
    #1;
    check("jmp_pcsrc", pcsrc, PC_JMP);
    check("jmp_target", pctarget, 32'h200);
    check("jmp_flush", flush, 1);
    check("jmp_stall", stall, 0);
    nop();

    // Timeout: no ack ever arrives
    memrd = 1; aluout = 32'h44; regwr = 1; regdstmux = 3;
    tick();
    busy = 0;
    while (dmem_req && busy < 40) begin
      busy++;
      tick();
    end
    nop();
    #1;
    check("tmo_busy_cycles", busy, 16);
    check("tmo_memerr", memerr, 1);
    check("tmo_regwr", regwrout, 0);
    check("tmo_regdst", regdstmuxout, 3);
    tick();
    tick();
    check("tmo_memerr_sticky", memerr, 1);
    check("tmo_req", dmem_req, 0);

    // Reset during the second BUSY cycle, then a stray ack
    memrd = 1; aluout = 32'h60; regwr = 1; regdstmux = 9; regdata2 = 32'h33;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    #1;
    check("rb_req", dmem_req, 0);
    check("rb_stall", stall, 0);
    check("rb_memerr", memerr, 0);
    check("rb_addr", dmem_addr, 0);
    check("rb_regdst", regdstmuxout, 0);
    dmem_ack = 1; dmem_rdata = 32'h99;
    tick();
    dmem_ack = 0;
    #1;
    check("rb_late_memdata", memdataout, 0);
    check("rb_late_regwr", regwrout, 0);
    check("rb_late_req", dmem_req, 0);
    check("rb_late_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
